// File: rtl/data_filter_pkg.sv
// Shared types and helpers for the data_filter stability filter.
package data_filter_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StCount
    } state_e;

    // Counter must hold values up to cnt_max.
    function automatic int unsigned cnt_width(input int unsigned cnt_max);
        return $clog2(cnt_max + 1);
    endfunction

endpackage

// File: rtl/data_filter_edge.sv
// Registered rising/falling bit masks, produced only in the cycle a new value is published.
module data_filter_edge #(
    parameter int unsigned D_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               accept_i,
    input  logic [D_WIDTH-1:0] new_i,
    input  logic [D_WIDTH-1:0] old_i,
    output logic [D_WIDTH-1:0] rise_o,
    output logic [D_WIDTH-1:0] fall_o
);

    logic [D_WIDTH-1:0] rise_d, rise_q;
    logic [D_WIDTH-1:0] fall_d, fall_q;

    always_comb begin
        rise_d = '0;
        fall_d = '0;
        if (accept_i) begin
            rise_d = new_i & ~old_i;
            fall_d = ~new_i & old_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/data_filter.sv
// Stability filter: publishes data_i only after it holds steady for CNT_MAX edges.
// Optional per-bit edge outputs rise_o/fall_o are built when DATA_FILTER_EDGE_EN is defined.
module data_filter
    import data_filter_pkg::*;
#(
    parameter int unsigned       D_WIDTH = 8,
    parameter int unsigned       CNT_MAX = 16,
    parameter logic [D_WIDTH-1:0] INIT   = '0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [D_WIDTH-1:0] data_i,
    output logic [D_WIDTH-1:0] data_o,
    output logic               valid_o,
    output logic               busy_o
`ifdef DATA_FILTER_EDGE_EN
    ,
    output logic [D_WIDTH-1:0] rise_o,
    output logic [D_WIDTH-1:0] fall_o
`endif
);

    localparam int unsigned  CntW    = cnt_width(CNT_MAX);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX - 1);

    state_e             state_d, state_q;
    logic [CntW-1:0]    cnt_d, cnt_q;
    logic [D_WIDTH-1:0] cand_d, cand_q;
    logic [D_WIDTH-1:0] data_d, data_q;
    logic               valid_d, valid_q;
    logic               busy_d, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        data_d  = data_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle: begin
                if (data_i != data_q) begin
                    if (CNT_MAX == 1) begin
                        data_d  = data_i;
                        valid_d = 1'b1;
                    end else begin
                        cand_d  = data_i;
                        cnt_d   = CntOne;
                        state_d = StCount;
                        busy_d  = 1'b1;
                    end
                end
            end
            StCount: begin
                if (data_i == data_q) begin
                    // Input fell back to the published value: drop the candidate.
                    state_d = StIdle;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (data_i != cand_q) begin
                    cand_d = data_i;
                    cnt_d  = CntOne;
                end else if (cnt_q == CntLast) begin
                    data_d  = cand_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= INIT;
            data_q  <= INIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

`ifdef DATA_FILTER_EDGE_EN
    data_filter_edge #(
        .D_WIDTH (D_WIDTH)
    ) u_edge (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .accept_i (valid_d),
        .new_i    (data_d),
        .old_i    (data_q),
        .rise_o   (rise_o),
        .fall_o   (fall_o)
    );
`else
    // Edge outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_data_filter.sv
// Self-checking bench for data_filter (D_WIDTH=8, CNT_MAX=4, INIT=0) against a run-length model.
module tb_data_filter;

    localparam int unsigned D_WIDTH = 8;
    localparam int unsigned CNT_MAX = 4;
    localparam logic [7:0]  INIT    = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i = 8'hA5;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy_o;
`ifdef DATA_FILTER_EDGE_EN
    logic [7:0] rise_o;
    logic [7:0] fall_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    data_filter #(
        .D_WIDTH (D_WIDTH),
        .CNT_MAX (CNT_MAX),
        .INIT    (INIT)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data_i  (data_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy_o  (busy_o)
`ifdef DATA_FILTER_EDGE_EN
        ,
        .rise_o  (rise_o),
        .fall_o  (fall_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference: a value is published once it has been sampled CNT_MAX times in a row
    // while differing from the currently published value.
    logic [7:0]  m_out;
    logic        m_valid;
    logic        m_busy;
    logic [7:0]  m_prev;
    logic        m_have;
    int unsigned m_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   <= INIT;
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_have  <= 1'b0;
            m_run   <= 0;
            m_prev  <= INIT;
        end else begin
            int unsigned run;
            logic        acc;
            run = (m_have && data_i == m_prev) ? m_run + 1 : 1;
            acc = (data_i != m_out) && (run >= CNT_MAX);
            m_run   <= run;
            m_prev  <= data_i;
            m_have  <= 1'b1;
            m_valid <= acc;
            if (acc) m_out <= data_i;
            m_busy  <= (data_i != m_out) && !acc;
        end
    end

    // Drive one value for one clock; returns just after the rising edge.
    task automatic cycle(input logic [7:0] v);
        @(negedge clk);
        data_i = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int pulses = 0;
        int at = 0;
        #1;
        n_checks++;
        if ({data_o, valid_o, busy_o} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%b/%b want 00/0/0", data_o, valid_o, busy_o);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(8'hA5);
            n_checks++;
            if ({data_o, valid_o, busy_o} !== {8'h00, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold: cyc %0d got %h/%b/%b want 00/0/0",
                         i, data_o, valid_o, busy_o);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cycle(8'hA5);
            if (valid_o) begin pulses++; at = i; end
            n_checks++;
            if ({data_o, valid_o, busy_o} !== {m_out, m_valid, m_busy}) begin
                n_fail++;
                $display("FAIL reset_release: edge %0d got %h/%b/%b want %h/%b/%b",
                         i, data_o, valid_o, busy_o, m_out, m_valid, m_busy);
            end
        end
        n_checks++;
        if (pulses != 1 || at != 4 || data_o !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_release_pulse: pulses=%0d edge=%0d data=%h want 1/4/a5",
                     pulses, at, data_o);
        end
    endtask

    task automatic test_clean_change();
        int pulses = 0;
        int at = 0;
        int busy_n = 0;
        for (int i = 0; i < 6; i++) cycle(8'h00);
        for (int i = 1; i <= 10; i++) begin
            cycle(8'h3C);
            if (valid_o) begin pulses++; at = i; end
            if (busy_o) busy_n++;
            n_checks++;
            if ({data_o, valid_o, busy_o} !== {m_out, m_valid, m_busy}) begin
                n_fail++;
                $display("FAIL clean: edge %0d got %h/%b/%b want %h/%b/%b",
                         i, data_o, valid_o, busy_o, m_out, m_valid, m_busy);
            end
        end
        n_checks++;
        if (pulses != 1 || at != 4 || busy_n != 3 || data_o !== 8'h3C) begin
            n_fail++;
            $display("FAIL clean_summary: pulses=%0d edge=%0d busy=%0d data=%h want 1/4/3/3c",
                     pulses, at, busy_n, data_o);
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 7; i++) begin
            cycle(i < 2 ? 8'hFF : 8'h3C);
            n_checks++;
            if (data_o !== 8'h3C || valid_o !== 1'b0 || busy_o !== (i < 2)) begin
                n_fail++;
                $display("FAIL glitch: cyc %0d got %h/%b/%b want 3c/0/%b",
                         i, data_o, valid_o, busy_o, i < 2);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int at = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(i[0] ? 8'h10 : 8'h11);
            n_checks++;
            if ({data_o, valid_o, busy_o} !== {8'h3C, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL bounce: cyc %0d got %h/%b/%b want 3c/0/1",
                         i, data_o, valid_o, busy_o);
            end
        end
        for (int i = 1; i <= 8; i++) begin
            cycle(8'h11);
            if (valid_o) begin pulses++; at = i; end
            n_checks++;
            if ({data_o, valid_o, busy_o} !== {m_out, m_valid, m_busy}) begin
                n_fail++;
                $display("FAIL bounce_settle: edge %0d got %h/%b/%b want %h/%b/%b",
                         i, data_o, valid_o, busy_o, m_out, m_valid, m_busy);
            end
        end
        n_checks++;
        if (pulses != 1 || at != 4 || data_o !== 8'h11) begin
            n_fail++;
            $display("FAIL bounce_pulse: pulses=%0d edge=%0d data=%h want 1/4/11",
                     pulses, at, data_o);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int at = 0;
        cycle(8'h55);
        cycle(8'h55);
        n_checks++;
        if ({data_o, valid_o, busy_o} !== {8'h11, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_pre: got %h/%b/%b want 11/0/1", data_o, valid_o, busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({data_o, valid_o, busy_o} !== {INIT, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_async: got %h/%b/%b want 00/0/0", data_o, valid_o, busy_o);
        end
        cycle(8'h55);
        cycle(8'h55);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            cycle(8'h55);
            if (valid_o) begin pulses++; at = i; end
            n_checks++;
            if ({data_o, valid_o, busy_o} !== {m_out, m_valid, m_busy}) begin
                n_fail++;
                $display("FAIL mid_release: edge %0d got %h/%b/%b want %h/%b/%b",
                         i, data_o, valid_o, busy_o, m_out, m_valid, m_busy);
            end
        end
        n_checks++;
        if (pulses != 1 || at != 4 || data_o !== 8'h55) begin
            n_fail++;
            $display("FAIL mid_pulse: pulses=%0d edge=%0d data=%h want 1/4/55",
                     pulses, at, data_o);
        end
    endtask

    task automatic test_random();
        logic [7:0] vals [4];
        vals[0] = 8'h00; vals[1] = 8'h3C; vals[2] = 8'h5A; vals[3] = 8'h5B;
        for (int seg = 0; seg < 80; seg++) begin
            logic [7:0] v;
            int unsigned len;
            v   = vals[$urandom_range(0, 3)];
            len = $urandom_range(1, 6);
            for (int k = 0; k < int'(len); k++) begin
                cycle(v);
                n_checks++;
                if ({data_o, valid_o, busy_o} !== {m_out, m_valid, m_busy}) begin
                    n_fail++;
                    $display("FAIL random: seg %0d got %h/%b/%b want %h/%b/%b",
                             seg, data_o, valid_o, busy_o, m_out, m_valid, m_busy);
                end
            end
        end
    endtask

`ifdef DATA_FILTER_EDGE_EN
    task automatic test_edge();
        for (int i = 0; i < 6; i++) cycle(8'h0F);
        for (int i = 1; i <= 7; i++) begin
            cycle(8'hF0);
            n_checks++;
            if (rise_o !== (m_valid ? 8'hF0 : 8'h00) || fall_o !== (m_valid ? 8'h0F : 8'h00)) begin
                n_fail++;
                $display("FAIL edge: edge %0d got rise=%h fall=%h valid=%b", i, rise_o, fall_o,
                         m_valid);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_change();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_random();
`ifdef DATA_FILTER_EDGE_EN
        test_edge();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_filter.md
Name: data_filter

Overview:
- Digital stability filter that sits directly downstream of the multi-bit `data_sync` synchronizer.
- Consumes the synchronized bus and publishes a new value only after it has stayed constant for a programmable number of clock cycles.
- Raises a one-cycle update strobe whenever the published value changes.
- Used to debounce and deglitch slow external status buses (DIP switches, strap pins, sensor codes) before control logic uses them.

Parameters:
- D_WIDTH, 8, bus width (must match the upstream `data_sync`).
- CNT_MAX, 16, consecutive equal samples required to accept a new value; legal range 1 to 65535.
- INIT, 0, reset value of `data_o` and of the candidate register (D_WIDTH bits).

Ports:
- clk_i  input  1  system clock; all logic is rising-edge.
- rst_n_i  input  1  reset, asynchronous and active-low.
- data_i  input  D_WIDTH  synchronized input bus (output of `data_sync`).
- data_o  output  D_WIDTH  filtered, stable bus value.
- valid_o  output  1  one-cycle pulse on the cycle `data_o` takes a new value.
- busy_o  output  1  high while a candidate value is being qualified.

Behaviour:
- All outputs and state are registered. One clock `clk_i`; reset is asynchronous, active-low on `rst_n_i`.
- Reset (`rst_n_i`=0), effective immediately without waiting for a clock:
  - `data_o`=INIT, `valid_o`=0, `busy_o`=0.
  - state=IDLE, cnt=0, cand=INIT.
- Internal registers:
  - cand: D_WIDTH candidate value.
  - cnt: counter of width $clog2(CNT_MAX+1).
  - state: IDLE or COUNT.
- IDLE, per rising edge:
  - `data_i`==`data_o`: stay in IDLE; `valid_o`=0.
  - `data_i`!=`data_o` and CNT_MAX==1: `data_o`<=`data_i`, `valid_o`<=1, stay in IDLE.
  - `data_i`!=`data_o` and CNT_MAX>1: cand<=`data_i`, cnt<=1, go to COUNT, `busy_o`<=1.
- COUNT, per rising edge, first matching rule wins:
  1. `data_i`==`data_o`: glitch rejected; go to IDLE, cnt<=0, `busy_o`<=0, no `valid_o`.
  2. `data_i`!=cand: bounce; cand<=`data_i`, cnt<=1, stay in COUNT.
  3. cnt==CNT_MAX-1: accept; `data_o`<=cand, `valid_o`<=1, cnt<=0, `busy_o`<=0, go to IDLE.
  4. Otherwise: cnt<=cnt+1.
- Latency: a clean change is first sampled at edge E1. `data_o` and `valid_o` update at edge E(CNT_MAX), i.e. CNT_MAX edges after the change is first seen. Add the `data_sync` latency on top for end-to-end timing.
- `valid_o` lasts exactly one cycle. Back-to-back `valid_o` cycles are possible only when CNT_MAX==1.
- cnt never exceeds CNT_MAX-1, so it cannot wrap.
- Reset asserted mid-qualification: the candidate is discarded and no `valid_o` is produced after release.
- After reset release, an input still different from INIT is qualified normally and produces `valid_o`.

Optional Feature:
- Macro: DATA_FILTER_EDGE_EN.
- When defined, two extra outputs exist:
  - `rise_o`  output  D_WIDTH: `cand & ~data_o_prev`.
  - `fall_o`  output  D_WIDTH: `~cand & data_o_prev`.
  - Both are registered and asserted only in the `valid_o` cycle; otherwise 0. Reset value 0.
- When not defined, these ports and their logic are absent and the block is otherwise identical.

Decomposition:
- Package `data_filter_pkg` holds:
  - the state enum typedef (IDLE, COUNT);
  - a counter-width localparam function, cnt_width(CNT_MAX) = $clog2(CNT_MAX+1).
- No sub-module in the base block. The optional edge logic is the natural sub-module `data_filter_edge`, instantiated only under DATA_FILTER_EDGE_EN.

Test Plan (D_WIDTH=8, CNT_MAX=4, INIT=0x00):
- Reset held 20 cycles with `data_i`=0xA5 -> `data_o`=0x00, `valid_o`=0, `busy_o`=0; after release `data_o`=0xA5 with a single `valid_o` pulse at the 4th edge.
- 0x00->0x3C held 10 cycles -> `busy_o`=1 for 3 cycles; `data_o`=0x3C with one `valid_o` pulse exactly 4 edges after the change; no further pulses.
- Stable 0x3C, then 0xFF for 2 cycles, then back to 0x3C -> `data_o` stays 0x3C, no `valid_o`, `busy_o` drops on return.
- Alternate 0x10/0x11 for 6 cycles, then hold 0x11 -> cnt restarts on each change; `valid_o` only 4 edges after the final settle; `data_o`=0x11.
- Change to 0x55, assert `rst_n_i` between clock edges when cnt=2 -> outputs reach INIT immediately; hold 0x55 after release -> qualification restarts from cnt=1.
- With DATA_FILTER_EDGE_EN, change 0x0F->0xF0 -> in the `valid_o` cycle `rise_o`=0xF0 and `fall_o`=0x0F; both 0x00 in all other cycles.
